sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- Sequencing controller directly upstream of the single-port SRAM. It turns a valid/ready push stream and a valid/ready pop stream into the SRAM's dataIn/Addr/WE/RD signals, so the SRAM behaves as a DPTH-entry FIFO.
- The SRAM allows only one operation per cycle: a write when WE=1/RD=0, or a registered read when RD=1/WE=0, with dataOut updated at the edge. The controller arbitrates pushes against reads and absorbs the one-cycle read latency.

Parameters:
DAT, 8, data width; matches the SRAM's DAT
DPTH, 8, SRAM entry count; must be a power of 2, >=2
AW, $clog2(DPTH), address/pointer width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  push request
in_ready  out  1  push accepted when in_valid && in_ready
in_data  in  DAT  push data
out_valid  out  1  out_data holds the FIFO head
out_ready  in  1  pop when out_valid && out_ready
out_data  out  DAT  head data; driven directly from sram_dataOut
sram_dataIn  out  DAT  to SRAM dataIn
sram_dataOut  in  DAT  from SRAM dataOut
sram_addr  out  AW  to SRAM Addr
sram_we  out  1  to SRAM WE
sram_rd  out  1  to SRAM RD
count  out  AW+1  total occupancy = mem_count + out_valid

Behaviour:
- State registers:
  - wr_ptr, rd_ptr (AW bits, wrap modulo DPTH)
  - mem_count (0..DPTH): entries written but not yet read-issued
  - out_valid
  - prio_rd (round-robin flag)
- Reset: asserting rst_n low clears all state immediately, regardless of clk.
  - wr_ptr=0, rd_ptr=0, mem_count=0, out_valid=0, prio_rd=0.
  - Resulting outputs: count=0, sram_we=0, sram_rd=0.
  - Reset mid-transfer discards all contents. SRAM array contents are don't-care.
- Signal definitions:
  - full = (mem_count==DPTH)
  - want_rd = (mem_count!=0) && (!out_valid || out_ready)
  - in_ready = !full && !(want_rd && prio_rd). It does not depend on in_valid.
  - push = in_valid && in_ready
  - issue_rd = want_rd && !push
- SRAM drive (combinational, same cycle):
  - On push: sram_we=1, sram_rd=0, sram_addr=wr_ptr, sram_dataIn=in_data.
  - On issue_rd: sram_rd=1, sram_we=0, sram_addr=rd_ptr.
  - Otherwise: sram_we=0, sram_rd=0. sram_addr and sram_dataIn are don't-care but must not be X.
  - sram_we and sram_rd are never both 1.
- Posedge updates:
  - push: wr_ptr++, mem_count++.
  - issue_rd: rd_ptr++, mem_count--, out_valid<=1. The SRAM's dataOut holds the new head from the next cycle.
  - Pop (out_valid && out_ready) without issue_rd: out_valid<=0.
  - Pop with issue_rd: out_valid stays 1 and the next head appears the following cycle. Throughput is 1 pop per cycle.
  - push and issue_rd are mutually exclusive, so mem_count changes by at most ±1 per cycle.
- Arbitration:
  - When both push and want_rd are possible, prio_rd selects the winner.
  - Whenever a push and a read contend, prio_rd toggles to favour the loser next time.
  - With no contention, prio_rd is unchanged.
- Latency:
  - Push to out_valid is 2 cycles minimum: write at edge N, read issued in cycle N+1, out_valid high after edge N+1.
  - There is no bypass path.
- out_data is stable while out_valid && !out_ready, because no read is issued in that case.
- Boundary conditions:
  - Full: in_ready=0. Reads still proceed.
  - Empty (mem_count=0): no read is issued; out_valid drains normally.
  - Pointers wrap from DPTH-1 to 0.
  - Total capacity is DPTH+1 (DPTH in the SRAM plus 1 held at the output).

Test Plan:
- Reset: hold rst_n=0, toggle in_valid -> count=0, out_valid=0, sram_we=0, sram_rd=0, in_ready=1 after release.
- Single item: push 0xA5 at cycle 0 with out_ready=0 -> sram_we=1, addr=0 in cycle 0; sram_rd=1, addr=0 in cycle 1; out_valid=1, out_data=0xA5 from cycle 2, stable until out_ready=1.
- Fill: push 0x01..0x09 with out_ready=0 -> 9 accepted, count=9, mem_count=8, in_ready=0; then pop all -> 0x01..0x09 in order, count returns to 0.
- Contention: preload 2 items, then hold in_valid=1 and out_ready=1 -> sram_we and sram_rd alternate cycle by cycle, never both high; no data lost or reordered.
- Wrap: stream 20 items 0x10..0x23 with out_ready=1 -> output identical in order; sram_addr wraps 7->0 on both pointers.
- Async reset mid-stream: drop rst_n between edges with count=5 -> outputs clear immediately; the first push after release is written to addr 0.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// Sequences a valid/ready push/pop pair onto a single-port SRAM so it acts as a DPTH-entry FIFO (plus one output slot).
// Push-to-out_valid is 2 cycles; push/read contention is round-robin; in_ready drops when full, when a read wins, or in reset.
module sram_fifo_ctrl #(
    parameter int DAT  = 8,
    parameter int DPTH = 8,
    parameter int AW   = $clog2(DPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DAT-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DAT-1:0] out_data,
    output logic [DAT-1:0] sram_dataIn,
    input  logic [DAT-1:0] sram_dataOut,
    output logic [AW-1:0]  sram_addr,
    output logic           sram_we,
    output logic           sram_rd,
    output logic [AW:0]    count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_count;
    logic          prio_rd;

    logic full;
    logic want_rd;
    logic push;
    logic issue_rd;
    logic pop;
    logic contend;

    assign full     = (mem_count == CNT_FULL);
    assign want_rd  = (mem_count != '0) && (!out_valid || out_ready);
    // Nothing is accepted while reset is asserted, so the SRAM never sees a write during reset.
    assign in_ready = rst_n && !full && !(want_rd && prio_rd);
    assign push     = in_valid && in_ready;
    assign issue_rd = want_rd && !push;
    assign pop      = out_valid && out_ready;
    assign contend  = in_valid && !full && want_rd;

    assign sram_we     = push;
    assign sram_rd     = issue_rd;
    assign sram_addr   = push ? wr_ptr : rd_ptr;
    assign sram_dataIn = push ? in_data : '0;
    assign out_data    = sram_dataOut;
    assign count       = mem_count + {{AW{1'b0}}, out_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            prio_rd   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                mem_count <= mem_count + CNT_ONE;
            end else if (issue_rd) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                mem_count <= mem_count - CNT_ONE;
            end
            // A read issued in the same cycle as a pop refills the output slot, keeping out_valid high.
            if (issue_rd) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (contend) begin
                prio_rd <= !prio_rd;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
module tb_sram_fifo_ctrl;

    localparam int DAT  = 8;
    localparam int DPTH = 8;
    localparam int AW   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DAT-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [DAT-1:0] out_data;
    logic [DAT-1:0] sram_dataIn;
    logic [DAT-1:0] sram_dataOut;
    logic [AW-1:0]  sram_addr;
    logic           sram_we;
    logic           sram_rd;
    logic [AW:0]    count;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DAT(DAT), .DPTH(DPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sram_dataIn(sram_dataIn), .sram_dataOut(sram_dataOut),
        .sram_addr(sram_addr), .sram_we(sram_we), .sram_rd(sram_rd),
        .count(count)
    );

    // Behavioural single-port SRAM with registered read.
    logic [DAT-1:0] mem [DPTH];
    logic [DAT-1:0] dout;
    assign sram_dataOut = dout;
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_dataIn;
        else if (sram_rd) dout <= mem[sram_addr];
    end

    // Reference model: queue of stored items, one output slot, a priority bit,
    // and running push/read totals whose residues give the expected addresses.
    logic [DAT-1:0] mq[$];
    logic [DAT-1:0] sent[$];
    logic [DAT-1:0] popped[$];
    bit             hv;
    logic [DAT-1:0] hd;
    bit             pr;
    int             npush, nread;
    bit             e_rdy, e_push, e_rd, e_cont;
    logic [AW-1:0]  e_addr;
    int             e_cnt;
    int             total = 0;
    int             bad = 0;

    task automatic model_reset();
        mq.delete(); sent.delete(); popped.delete();
        hv = 0; pr = 0; npush = 0; nread = 0;
    endtask

    task automatic model_eval();
        bit full, want;
        full   = (mq.size() == DPTH);
        want   = (mq.size() != 0) && (!hv || out_ready);
        e_rdy  = rst_n && !full && !(want && pr);
        e_push = in_valid && e_rdy;
        e_rd   = want && !e_push;
        e_cont = in_valid && !full && want;
        e_addr = e_push ? AW'(npush % DPTH) : AW'(nread % DPTH);
        e_cnt  = mq.size() + int'(hv);
    endtask

    task automatic drive(input bit iv, input logic [DAT-1:0] d, input bit ordy);
        @(negedge clk);
        in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        model_eval();
        if (e_push) sent.push_back(d);
    endtask

    task automatic tick();
        @(posedge clk);
        if (e_cont) pr = !pr;
        if (hv && out_ready) popped.push_back(hd);
        if (e_push) begin mq.push_back(in_data); npush++; end
        if (e_rd) begin hd = mq.pop_front(); hv = 1; nread++; end
        else if (hv && out_ready) hv = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid; in_data = 8'(i + 1);
            #1;
            total++;
            if ({count, out_valid, sram_we, sram_rd} !== 7'b0) begin
                bad++;
                $display("FAIL reset.outs got cnt=%0d ov=%b we=%b rd=%b exp all 0", count, out_valid, sram_we, sram_rd);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || count !== 4'd0) begin
            bad++;
            $display("FAIL reset.release got in_ready=%b cnt=%0d exp 1/0", in_ready, count);
        end
    endtask

    task automatic test_single();
        drive(1, 8'hA5, 0);
        total++;
        if ({sram_we, sram_rd, sram_addr, sram_dataIn} !== {1'b1, 1'b0, 3'd0, 8'hA5}) begin
            bad++;
            $display("FAIL single.write got we=%b rd=%b a=%0d d=%h exp 1/0/0/a5", sram_we, sram_rd, sram_addr, sram_dataIn);
        end
        tick();
        drive(0, 8'h00, 0);
        total++;
        if ({sram_we, sram_rd, sram_addr, out_valid} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL single.read got we=%b rd=%b a=%0d ov=%b exp 0/1/0/0", sram_we, sram_rd, sram_addr, out_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 8'h00, i == 3);
            total++;
            if ({out_valid, out_data, count} !== {1'b1, 8'hA5, 4'd1}) begin
                bad++;
                $display("FAIL single.hold%0d got ov=%b d=%h cnt=%0d exp 1/a5/1", i, out_valid, out_data, count);
            end
            tick();
        end
        drive(0, 8'h00, 0);
        total++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            bad++;
            $display("FAIL single.empty got ov=%b cnt=%0d exp 0/0", out_valid, count);
        end
        tick();
    endtask

    task automatic test_fill();
        int k = 1;
        sent.delete(); popped.delete();
        for (int c = 0; c < 60 && k <= 9; c++) begin
            drive(1, 8'(k), 0);
            total++;
            if ({in_ready, sram_we, sram_rd, out_valid, count} !== {e_rdy, e_push, e_rd, hv, 4'(e_cnt)}) begin
                bad++;
                $display("FAIL fill.ctl got=%b exp=%b", {in_ready, sram_we, sram_rd, out_valid, count}, {e_rdy, e_push, e_rd, hv, 4'(e_cnt)});
            end
            if (e_push) k++;
            tick();
        end
        drive(1, 8'h0A, 0);
        total++;
        if (in_ready !== 1'b0 || count !== 4'd9 || mq.size() != 8) begin
            bad++;
            $display("FAIL fill.full got in_ready=%b cnt=%0d exp 0/9", in_ready, count);
        end
        tick();
        for (int c = 0; c < 40 && (mq.size() != 0 || hv); c++) begin
            drive(0, 8'h00, 1);
            total++;
            if ({in_ready, sram_we, sram_rd, out_valid, count} !== {e_rdy, e_push, e_rd, hv, 4'(e_cnt)}) begin
                bad++;
                $display("FAIL fill.drain got=%b exp=%b", {in_ready, sram_we, sram_rd, out_valid, count}, {e_rdy, e_push, e_rd, hv, 4'(e_cnt)});
            end
            if (hv) begin
                total++;
                if (out_data !== hd) begin bad++; $display("FAIL fill.data got=%h exp=%h", out_data, hd); end
            end
            tick();
        end
        total++;
        if (popped.size() != 9) begin bad++; $display("FAIL fill.npop got=%0d exp=9", popped.size()); end
        foreach (popped[i]) begin
            total++;
            if (popped[i] !== 8'(i + 1)) begin bad++; $display("FAIL fill.order[%0d] got=%h exp=%h", i, popped[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_contention();
        int k = 0;
        int alt = 0;
        sent.delete(); popped.delete();
        for (int c = 0; c < 20 && k < 2; c++) begin
            drive(1, 8'(8'h40 + k), 0);
            if (e_push) k++;
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            drive(1, 8'(8'h40 + k), 1);
            total++;
            if ({in_ready, sram_we, sram_rd, out_valid, count} !== {e_rdy, e_push, e_rd, hv, 4'(e_cnt)}) begin
                bad++;
                $display("FAIL cont.ctl got=%b exp=%b", {in_ready, sram_we, sram_rd, out_valid, count}, {e_rdy, e_push, e_rd, hv, 4'(e_cnt)});
            end
            if (e_push || e_rd) begin
                total++;
                if (sram_addr !== e_addr) begin bad++; $display("FAIL cont.addr got=%0d exp=%0d", sram_addr, e_addr); end
            end
            if (c > 0 && sram_we !== sram_rd) alt++;
            if (e_push) k++;
            tick();
        end
        total++;
        if (alt != 15) begin bad++; $display("FAIL cont.alternate got=%0d exp=15 one-hot cycles", alt); end
        for (int c = 0; c < 40 && (mq.size() != 0 || hv); c++) begin
            drive(0, 8'h00, 1);
            tick();
        end
        total++;
        if (popped.size() != sent.size() || sent.size() < 8) begin
            bad++;
            $display("FAIL cont.npop got=%0d exp=%0d", popped.size(), sent.size());
        end
        foreach (popped[i]) begin
            total++;
            if (popped[i] !== sent[i]) begin bad++; $display("FAIL cont.order[%0d] got=%h exp=%h", i, popped[i], sent[i]); end
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        bit ww = 0, rw = 0;
        sent.delete(); popped.delete();
        for (int c = 0; c < 200 && (k < 20 || mq.size() != 0 || hv); c++) begin
            drive(k < 20, 8'(8'h10 + k), 1);
            total++;
            if ({in_ready, sram_we, sram_rd, out_valid, count} !== {e_rdy, e_push, e_rd, hv, 4'(e_cnt)}) begin
                bad++;
                $display("FAIL wrap.ctl got=%b exp=%b", {in_ready, sram_we, sram_rd, out_valid, count}, {e_rdy, e_push, e_rd, hv, 4'(e_cnt)});
            end
            if (e_push || e_rd) begin
                total++;
                if (sram_addr !== e_addr) begin bad++; $display("FAIL wrap.addr got=%0d exp=%0d", sram_addr, e_addr); end
            end
            if (hv) begin
                total++;
                if (out_data !== hd) begin bad++; $display("FAIL wrap.data got=%h exp=%h", out_data, hd); end
            end
            if (e_push && npush >= DPTH && (npush % DPTH) == 0 && sram_addr === 3'd0) ww = 1;
            if (e_rd && nread >= DPTH && (nread % DPTH) == 0 && sram_addr === 3'd0) rw = 1;
            if (e_push) k++;
            tick();
        end
        total++;
        if (!(ww && rw)) begin bad++; $display("FAIL wrap.ptrs got wr_wrap=%b rd_wrap=%b exp 1/1", ww, rw); end
        total++;
        if (popped.size() != 20) begin bad++; $display("FAIL wrap.npop got=%0d exp=20", popped.size()); end
        foreach (popped[i]) begin
            total++;
            if (popped[i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL wrap.order[%0d] got=%h exp=%h", i, popped[i], 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_random();
        sent.delete(); popped.delete();
        for (int c = 0; c < 600; c++) begin
            if (c < 500) drive($urandom_range(0, 3) != 0 ? (c % 200 < 100 || $urandom_range(0, 1) == 1) : 1'b0,
                               8'($urandom), (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            else drive(0, 8'h00, $urandom_range(0, 1) == 1);
            total++;
            if ({in_ready, sram_we, sram_rd, out_valid, count} !== {e_rdy, e_push, e_rd, hv, 4'(e_cnt)}) begin
                bad++;
                $display("FAIL rand.ctl c=%0d got=%b exp=%b", c, {in_ready, sram_we, sram_rd, out_valid, count}, {e_rdy, e_push, e_rd, hv, 4'(e_cnt)});
            end
            if (e_push || e_rd) begin
                total++;
                if (sram_addr !== e_addr) begin bad++; $display("FAIL rand.addr got=%0d exp=%0d", sram_addr, e_addr); end
            end
            if (e_push) begin
                total++;
                if (sram_dataIn !== in_data) begin bad++; $display("FAIL rand.din got=%h exp=%h", sram_dataIn, in_data); end
            end
            if (hv) begin
                total++;
                if (out_data !== hd) begin bad++; $display("FAIL rand.data got=%h exp=%h", out_data, hd); end
            end
            tick();
        end
        total++;
        if (mq.size() != 0 || hv || popped.size() != sent.size()) begin
            bad++;
            $display("FAIL rand.drain got popped=%0d exp=%0d", popped.size(), sent.size());
        end
        foreach (popped[i]) begin
            if (i < sent.size()) begin
                total++;
                if (popped[i] !== sent[i]) begin bad++; $display("FAIL rand.order[%0d] got=%h exp=%h", i, popped[i], sent[i]); end
            end
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        for (int c = 0; c < 40 && (mq.size() + int'(hv)) < 5; c++) begin
            drive(1, 8'(8'h60 + k), 0);
            if (e_push) k++;
            tick();
        end
        drive(0, 8'h00, 0);
        total++;
        if (count !== 4'd5) begin bad++; $display("FAIL arst.pre got cnt=%0d exp=5", count); end
        #1;
        rst_n = 1'b0; in_valid = 1'b1;
        #1;
        total++;
        if ({count, out_valid, sram_we, sram_rd} !== 7'b0) begin
            bad++;
            $display("FAIL arst.clear got cnt=%0d ov=%b we=%b rd=%b exp all 0", count, out_valid, sram_we, sram_rd);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        drive(1, 8'h77, 0);
        total++;
        if ({sram_we, sram_addr, sram_dataIn} !== {1'b1, 3'd0, 8'h77}) begin
            bad++;
            $display("FAIL arst.first got we=%b a=%0d d=%h exp 1/0/77", sram_we, sram_addr, sram_dataIn);
        end
        tick();
        for (int c = 0; c < 20 && (mq.size() != 0 || hv); c++) begin
            drive(0, 8'h00, 1);
            tick();
        end
        total++;
        if (popped.size() != 1 || popped[0] !== 8'h77) begin
            bad++;
            $display("FAIL arst.drain got n=%0d exp one item 77", popped.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_contention();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
